// File: rtl/fifo_stream_pkg.sv
// Shared constants and helpers for the FIFO read-side drain stage.
package fifo_stream_pkg;

    localparam int unsigned BUF_DEPTH = 3;
    localparam int unsigned PTR_W     = 2;
    localparam int unsigned CNT_W     = 2;

    // Advance a buffer pointer, wrapping from the last entry back to 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream seen by the drain stage.
interface fifo_rd_stream_if #(
    parameter int unsigned WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_rd_en;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        input  fifo_empty, fifo_rd_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_rd_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo.sv
// Synchronous FIFO with one-cycle registered read data and sticky error flags.
module fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             rd_error,
    output logic             wr_error
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr, do_rd;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rd_data  <= '0;
            rd_error <= 1'b0;
            wr_error <= 1'b0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_data  <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_wr && !do_rd)      count_q <= count_q + 1'b1;
            else if (!do_wr && do_rd) count_q <= count_q - 1'b1;
            if (rd_en && empty) rd_error <= 1'b1;
            if (wr_en && full)  wr_error <= 1'b1;
        end
    end
endmodule

// File: rtl/fifo_rd_skid_buf.sv
// Three-entry circular buffer absorbing the FIFO read latency.
module fifo_rd_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] cnt
);
    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (push) tail_d = ptr_inc(tail_q);
        if (pop)  head_d = ptr_inc(head_q);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) mem_q[i] <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) mem_q[tail_q] <= push_data;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_data = mem_q[head_q];
    assign cnt       = cnt_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO drain stage: credit-based read issue, capture buffer and packet framing.
module fifo_rd_stream
    import fifo_stream_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PKT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    fifo_rd_stream_if.master bus
);
    localparam int unsigned BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    logic              inflight_q, inflight_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  head_data;
    logic              rd_en_c, valid_c, pop_c, last_beat_c, credit_ok_c;

    // Credit counts both stored words and the word still in flight from the FIFO.
    assign credit_ok_c = (3'({1'b0, cnt}) + 3'(inflight_q)) < 3'(BUF_DEPTH);
    assign last_beat_c = (beat_q == BEAT_W'(PKT_LEN - 1));

    always_comb begin
        rd_en_c    = !rst && enable && !bus.fifo_empty && credit_ok_c;
        valid_c    = (cnt != '0);
        pop_c      = valid_c && bus.m_ready;
        inflight_d = rd_en_c;
        beat_d     = beat_q;
        if (pop_c) beat_d = last_beat_c ? '0 : beat_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            beat_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
        end
    end

    fifo_rd_skid_buf #(.WIDTH(WIDTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (bus.fifo_rd_data),
        .pop       (pop_c),
        .head_data (head_data),
        .cnt       (cnt)
    );

    assign bus.fifo_rd_en = rd_en_c;
    assign bus.m_valid    = valid_c;
    assign bus.m_data     = head_data;
    assign bus.m_last     = valid_c && last_beat_c;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream fed by the real 16-deep FIFO.
module tb_fifo_rd_stream;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned PKT_LEN = 4;
    localparam int unsigned DEPTH   = 16;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             enable  = 1'b0;
    logic             wr_en   = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             full, rd_error, wr_error;

    fifo_rd_stream_if #(.WIDTH(WIDTH)) bus ();

    fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (bus.fifo_rd_en),
        .rd_data  (bus.fifo_rd_data),
        .full     (full),
        .empty    (bus.fifo_empty),
        .rd_error (rd_error),
        .wr_error (wr_error)
    );

    fifo_rd_stream #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [WIDTH:0] exp_q [$];
    logic [WIDTH:0] obs_q [$];
    int             obs_cyc [$];
    int             exp_beat = 0;
    int             rd_cnt   = 0;
    int             bad_rd   = 0;
    int             cyc      = 0;
    int             n_checks = 0;
    int             n_fails  = 0;

    // Monitor only records what the DUT does; tasks judge it.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (bus.fifo_rd_en) rd_cnt++;
            if (bus.fifo_rd_en && bus.fifo_empty) bad_rd++;
            if (bus.m_valid && bus.m_ready) begin
                obs_q.push_back({bus.m_last, bus.m_data});
                obs_cyc.push_back(cyc);
            end
        end
    end

    task automatic write_words(input int n, input int base, input int step);
        logic l;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            wr_en   = 1'b1;
            wr_data = WIDTH'(base + i * step);
            l = (exp_beat == int'(PKT_LEN) - 1);
            exp_q.push_back({l, wr_data});
            exp_beat = l ? 0 : exp_beat + 1;
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, output bit timeout);
        int c = 0;
        timeout = 1'b0;
        while (obs_q.size() < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        if (obs_q.size() < n) timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_in: rd_en=%b m_valid=%b, required 0 0", bus.fifo_rd_en, bus.m_valid);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.fifo_rd_en, bus.m_valid, bus.m_last} !== 3'b000 || bus.m_data !== '0) begin
            n_fails++;
            $display("FAIL reset_out: rd_en=%b valid=%b last=%b data=%0d, required 0 0 0 0",
                     bus.fifo_rd_en, bus.m_valid, bus.m_last, bus.m_data);
        end
    endtask

    task automatic test_empty();
        int bad = 0;
        enable = 1'b1;
        bus.m_ready = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0 || rd_error !== 1'b0) begin
            n_fails++;
            $display("FAIL empty_idle: %0d active cycles, rd_error=%b, required 0 and 0", bad, rd_error);
        end
    endtask

    task automatic test_drain();
        bit to;
        logic [WIDTH:0] e, o;
        int gaps = 0;
        enable = 1'b0;
        bus.m_ready = 1'b1;
        write_words(16, 0, 2);
        enable = 1'b1;
        wait_beats(16, 100, to);
        n_checks++;
        if (to) begin
            n_fails++;
            $display("FAIL drain_timeout: got %0d beats, required 16", obs_q.size());
        end
        for (int i = 1; i < obs_cyc.size(); i++)
            if (obs_cyc[i] != obs_cyc[i-1] + 1) gaps++;
        n_checks++;
        if (gaps != 0) begin
            n_fails++;
            $display("FAIL drain_throughput: %0d gaps, required 0", gaps);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL drain_beat: data=%0d last=%b, required data=%0d last=%b",
                         o[WIDTH-1:0], o[WIDTH], e[WIDTH-1:0], e[WIDTH]);
            end
        end
        obs_cyc.delete();
        @(posedge clk); #1;
        n_checks++;
        if (rd_error !== 1'b0 || bus.fifo_empty !== 1'b1 || bad_rd != 0) begin
            n_fails++;
            $display("FAIL drain_end: rd_error=%b empty=%b bad_rd=%0d, required 0 1 0",
                     rd_error, bus.fifo_empty, bad_rd);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [WIDTH:0] e, o;
        int r0, unstable = 0;
        enable = 1'b0;
        bus.m_ready = 1'b0;
        write_words(16, 0, 2);
        r0 = rd_cnt;
        enable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.m_valid && (bus.m_data !== '0 || bus.m_last !== 1'b0)) unstable++;
        end
        n_checks++;
        if (rd_cnt - r0 != 3) begin
            n_fails++;
            $display("FAIL bp_reads: %0d reads during stall, required 3", rd_cnt - r0);
        end
        n_checks++;
        if (unstable != 0 || bus.m_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL bp_hold: %0d unstable cycles, valid=%b, required 0 and 1", unstable, bus.m_valid);
        end
        bus.m_ready = 1'b1;
        wait_beats(16, 100, to);
        n_checks++;
        if (to) begin
            n_fails++;
            $display("FAIL bp_timeout: got %0d beats, required 16", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL bp_beat: data=%0d last=%b, required data=%0d last=%b",
                         o[WIDTH-1:0], o[WIDTH], e[WIDTH-1:0], e[WIDTH]);
            end
        end
        obs_cyc.delete();
        n_checks++;
        if (rd_error !== 1'b0 || exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL bp_end: rd_error=%b left=%0d, required 0 0", rd_error, exp_q.size());
        end
    endtask

    task automatic test_random_ready();
        logic [WIDTH:0] e, o;
        int c = 0, lasts = 0;
        enable = 1'b0;
        bus.m_ready = 1'b0;
        write_words(16, 1, 3);
        enable = 1'b1;
        while (obs_q.size() < 16 && c < 400) begin
            @(posedge clk); #1;
            bus.m_ready = 1'($urandom_range(0, 1));
            c++;
        end
        bus.m_ready = 1'b1;
        for (int i = 0; i < obs_q.size(); i++) if (obs_q[i][WIDTH]) lasts++;
        n_checks++;
        if (obs_q.size() != 16 || lasts != 4) begin
            n_fails++;
            $display("FAIL rand_count: beats=%0d lasts=%0d, required 16 and 4", obs_q.size(), lasts);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL rand_beat: data=%0d last=%b, required data=%0d last=%b",
                         o[WIDTH-1:0], o[WIDTH], e[WIDTH-1:0], e[WIDTH]);
            end
        end
        obs_cyc.delete();
    endtask

    task automatic test_enable_pause();
        bit to;
        logic [WIDTH:0] e, o;
        int r0;
        enable = 1'b0;
        bus.m_ready = 1'b1;
        write_words(16, 100, 5);
        enable = 1'b1;
        wait_beats(5, 50, to);
        enable = 1'b0;
        r0 = rd_cnt;
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (to || rd_cnt != r0 || obs_q.size() >= 16) begin
            n_fails++;
            $display("FAIL pause_reads: timeout=%b extra reads=%0d beats=%0d, required 0 0 <16",
                     to, rd_cnt - r0, obs_q.size());
        end
        enable = 1'b1;
        wait_beats(16, 100, to);
        n_checks++;
        if (to) begin
            n_fails++;
            $display("FAIL pause_timeout: got %0d beats, required 16", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL pause_beat: data=%0d last=%b, required data=%0d last=%b",
                         o[WIDTH-1:0], o[WIDTH], e[WIDTH-1:0], e[WIDTH]);
            end
        end
        obs_cyc.delete();
    endtask

    task automatic test_reset_midstream();
        bit to;
        logic [WIDTH:0] e, o;
        enable = 1'b0;
        bus.m_ready = 1'b0;
        write_words(16, 50, 1);
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== WIDTH'(50)) begin
            n_fails++;
            $display("FAIL rst_pre: valid=%b data=%0d, required 1 50", bus.m_valid, bus.m_data);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
        exp_beat = 0;
        n_checks++;
        if (bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 || bus.fifo_empty !== 1'b1) begin
            n_fails++;
            $display("FAIL rst_post: valid=%b last=%b empty=%b, required 0 0 1",
                     bus.m_valid, bus.m_last, bus.fifo_empty);
        end
        bus.m_ready = 1'b1;
        write_words(4, 90, 1);
        wait_beats(4, 50, to);
        n_checks++;
        if (to || obs_q.size() != 4) begin
            n_fails++;
            $display("FAIL rst_refill_count: got %0d beats, required 4", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fails++;
                $display("FAIL rst_refill_beat: data=%0d last=%b, required data=%0d last=%b",
                         o[WIDTH-1:0], o[WIDTH], e[WIDTH-1:0], e[WIDTH]);
            end
        end
        obs_cyc.delete();
        n_checks++;
        if (rd_error !== 1'b0 || bad_rd != 0) begin
            n_fails++;
            $display("FAIL final_errors: rd_error=%b bad_rd=%0d, required 0 0", rd_error, bad_rd);
        end
    endtask

    initial begin
        bus.m_ready = 1'b0;
        test_reset();
        test_empty();
        test_drain();
        test_backpressure();
        test_random_ready();
        test_enable_pause();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
